// File: rtl/ctrl_bus_arbiter.sv
// Two-requester round-robin arbiter issuing single-outstanding AXI4-Lite
// full-word reads and writes on behalf of whichever requester wins.
module ctrl_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WADDR = 3'd1;
  localparam logic [2:0] S_WRESP = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RRESP = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic                  gnt_idx_s;
  logic                  grant_s;
  logic [1:0]            req_ready_s;

  // Round-robin pick; the pointer only matters when both requesters compete.
  // The grant is gated by ARESETN so req_ready is low throughout reset.
  always_comb begin
    gnt_idx_s = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_idx_s = ptr_q;
    end else if (req_valid[1]) begin
      gnt_idx_s = 1'b1;
    end else begin
      gnt_idx_s = 1'b0;
    end
    grant_s = ARESETN && (state_q == S_IDLE) && (req_valid != 2'b00);
    if (grant_s) begin
      req_ready_s = gnt_idx_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_s = 2'b00;
    end
  end

  // Transaction sequencing: one AXI command in flight, AW and W retire independently.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          idx_d   = gnt_idx_s;
          ptr_d   = ~gnt_idx_s;
          addr_d  = gnt_idx_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_d = gnt_idx_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          if (req_write[gnt_idx_s]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WADDR: begin
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
        end else begin
          awvalid_d = awvalid_q;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
        end else begin
          wvalid_d = wvalid_q;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d = S_WRESP;
        end else begin
          state_d = S_WADDR;
        end
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          rsp_valid_d = idx_q ? 2'b10 : 2'b01;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = S_IDLE;
        end else begin
          state_d = S_WRESP;
        end
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = S_RRESP;
        end else begin
          state_d = S_RADDR;
        end
      end
      S_RRESP: begin
        if (M_AXI_RVALID) begin
          rsp_valid_d = idx_q ? 2'b10 : 2'b01;
          rsp_resp_d  = M_AXI_RRESP;
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RRESP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction silently.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      idx_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign req_ready     = req_ready_s;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = (state_q != S_IDLE);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_WRESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == S_RRESP);

endmodule

// File: tb/tb_ctrl_bus_arbiter.sv
// Randomized bench for ctrl_bus_arbiter: requester queues, a delay-programmable
// AXI4-Lite slave, and a transaction-level scoreboard built from the arbitration rules.
module tb_ctrl_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [1:0]    req_valid, req_write, req_ready, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
  logic [DW-1:0] M_AXI_WDATA, M_AXI_RDATA;
  logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
  logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic          M_AXI_RVALID, M_AXI_RREADY;

  ctrl_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic          idx;
    logic          wr;
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } exp_t;

  cmd_t q0[$];
  cmd_t q1[$];
  exp_t expq[$];
  int   grant_log[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] smem [logic [AW-1:0]];
  int   total = 0;
  int   bad = 0;
  logic ptr_m;
  logic [DW-1:0] last_rdata_m;
  logic [1:0] active;
  bit   rand_withdraw;

  // slave configuration and state
  int   aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit   rand_dly;
  logic [1:0] bresp_cfg, rresp_cfg;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [DW-1:0] s_wdata;

  // history of the previous sample for per-channel protocol checks
  bit   hist_ok;
  logic p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready, p_bhs, p_rhs;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  bit   fp;
  logic fp_wr;
  int   aw_only_cycles;

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a ^ 32'hC3C3_5A5A;
  endfunction

  // AXI4-Lite slave: each ready/valid comes after a programmable number of cycles.
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (M_AXI_AWREADY) M_AXI_AWREADY = 1'b0;
      else if (M_AXI_AWVALID) begin
        if (aw_cnt >= aw_dly) begin
          M_AXI_AWREADY = 1'b1; aw_cnt = 0; s_awaddr = M_AXI_AWADDR;
          if (rand_dly) aw_dly = $urandom_range(0, 3);
        end else aw_cnt++;
      end
      if (M_AXI_WREADY) M_AXI_WREADY = 1'b0;
      else if (M_AXI_WVALID) begin
        if (w_cnt >= w_dly) begin
          M_AXI_WREADY = 1'b1; w_cnt = 0; s_wdata = M_AXI_WDATA;
          if (rand_dly) w_dly = $urandom_range(0, 3);
        end else w_cnt++;
      end
      if (M_AXI_BVALID) M_AXI_BVALID = 1'b0;
      else if (M_AXI_BREADY) begin
        if (b_cnt >= b_dly) begin
          M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_cfg; b_cnt = 0;
          if (bresp_cfg == 2'b00) smem[s_awaddr] = s_wdata;
          if (rand_dly) b_dly = $urandom_range(0, 3);
        end else b_cnt++;
      end
      if (M_AXI_ARREADY) M_AXI_ARREADY = 1'b0;
      else if (M_AXI_ARVALID) begin
        if (ar_cnt >= ar_dly) begin
          M_AXI_ARREADY = 1'b1; ar_cnt = 0; s_araddr = M_AXI_ARADDR;
          if (rand_dly) ar_dly = $urandom_range(0, 3);
        end else ar_cnt++;
      end
      if (M_AXI_RVALID) M_AXI_RVALID = 1'b0;
      else if (M_AXI_RREADY) begin
        if (r_cnt >= r_dly) begin
          M_AXI_RVALID = 1'b1; M_AXI_RRESP = rresp_cfg; r_cnt = 0;
          M_AXI_RDATA = smem.exists(s_araddr) ? smem[s_araddr] : dflt(s_araddr);
          if (rand_dly) r_dly = $urandom_range(0, 3);
        end else r_cnt++;
      end
    end
  end

  task automatic set_slave(input int d_aw, input int d_w, input int d_b, input int d_ar, input int d_r);
    aw_dly = d_aw; w_dly = d_w; b_dly = d_b; ar_dly = d_ar; r_dly = d_r;
  endtask

  // One clock of stimulus plus scoreboard checks, sampled 1 time unit after the falling edge.
  task automatic step();
    cmd_t h0, h1, c;
    exp_t e;
    logic v0, v1, win;
    logic [1:0] want;
    @(negedge ACLK);
    v0 = active[0] && (q0.size() > 0) && (!rand_withdraw || $urandom_range(0, 3) != 0);
    v1 = active[1] && (q1.size() > 0) && (!rand_withdraw || $urandom_range(0, 3) != 0);
    if (q0.size() > 0) h0 = q0[0];
    else begin h0.wr = 1'b0; h0.addr = $urandom(); h0.data = $urandom(); end
    if (q1.size() > 0) h1 = q1[0];
    else begin h1.wr = 1'b1; h1.addr = $urandom(); h1.data = $urandom(); end
    req_valid = {v1, v0};
    req_write = {h1.wr, h0.wr};
    req_addr  = {h1.addr, h0.addr};
    req_wdata = {h1.data, h0.data};
    #1;
    if (M_AXI_AWVALID && !M_AXI_WVALID) aw_only_cycles++;
    total++;
    if ((rsp_valid != 2'b00) !== (hist_ok && (p_bhs || p_rhs))) begin
      bad++; $display("FAIL rsp_timing: rsp_valid=%b, prior B/R handshake=%b", rsp_valid, hist_ok && (p_bhs || p_rhs));
    end
    if (rsp_valid != 2'b00) begin
      total++;
      if (expq.size() == 0) begin
        bad++; $display("FAIL rsp_unexpected: rsp_valid=%b with nothing outstanding", rsp_valid);
      end else begin
        e = expq.pop_front();
        if (!e.wr) last_rdata_m = e.rdata;
        if (rsp_valid !== (e.idx ? 2'b10 : 2'b01) || rsp_resp !== e.resp || rsp_rdata !== last_rdata_m) begin
          bad++;
          $display("FAIL rsp: got valid=%b resp=%b rdata=%h, want valid=%b resp=%b rdata=%h",
                   rsp_valid, rsp_resp, rsp_rdata, e.idx ? 2'b10 : 2'b01, e.resp, last_rdata_m);
        end
      end
    end
    total++;
    if (busy !== (expq.size() != 0)) begin
      bad++; $display("FAIL busy: got %b want %b", busy, expq.size() != 0);
    end
    if (fp) begin
      total++;
      if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID} !== (fp_wr ? 3'b110 : 3'b001)) begin
        bad++; $display("FAIL first_beat: AW/W/AR valid=%b want %b",
                        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, fp_wr ? 3'b110 : 3'b001);
      end
      fp = 1'b0;
    end
    if (hist_ok && p_awvalid) begin
      total++;
      if (p_awready ? (M_AXI_AWVALID !== 1'b0) : (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== p_awaddr)) begin
        bad++; $display("FAIL aw_chan: AWVALID=%b AWADDR=%h after ready=%b addr=%h", M_AXI_AWVALID, M_AXI_AWADDR, p_awready, p_awaddr);
      end
    end
    if (hist_ok && p_wvalid) begin
      total++;
      if (p_wready ? (M_AXI_WVALID !== 1'b0) : (M_AXI_WVALID !== 1'b1 || M_AXI_WDATA !== p_wdata)) begin
        bad++; $display("FAIL w_chan: WVALID=%b WDATA=%h after ready=%b data=%h", M_AXI_WVALID, M_AXI_WDATA, p_wready, p_wdata);
      end
    end
    if (hist_ok && p_arvalid) begin
      total++;
      if (p_arready ? (M_AXI_ARVALID !== 1'b0) : (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== p_araddr)) begin
        bad++; $display("FAIL ar_chan: ARVALID=%b ARADDR=%h after ready=%b addr=%h", M_AXI_ARVALID, M_AXI_ARADDR, p_arready, p_araddr);
      end
    end
    want = 2'b00;
    win  = 1'b0;
    if (expq.size() == 0 && req_valid != 2'b00) begin
      win  = (req_valid == 2'b11) ? ptr_m : req_valid[1];
      want = win ? 2'b10 : 2'b01;
    end
    total++;
    if (req_ready !== want) begin
      bad++; $display("FAIL grant: req_ready=%b want %b (req_valid=%b)", req_ready, want, req_valid);
    end else if (want != 2'b00) begin
      c = win ? q1.pop_front() : q0.pop_front();
      e.idx = win;
      e.wr  = c.wr;
      if (c.wr) begin
        e.resp = bresp_cfg; e.rdata = '0;
        if (bresp_cfg == 2'b00) ref_mem[c.addr] = c.data;
      end else begin
        e.resp  = rresp_cfg;
        e.rdata = ref_mem.exists(c.addr) ? ref_mem[c.addr] : dflt(c.addr);
      end
      expq.push_back(e);
      ptr_m = ~win;
      grant_log.push_back(int'(win));
      fp = 1'b1; fp_wr = c.wr;
    end
    p_awvalid = M_AXI_AWVALID; p_awready = M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
    p_wvalid  = M_AXI_WVALID;  p_wready  = M_AXI_WREADY;  p_wdata  = M_AXI_WDATA;
    p_arvalid = M_AXI_ARVALID; p_arready = M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
    p_bhs = M_AXI_BVALID && M_AXI_BREADY;
    p_rhs = M_AXI_RVALID && M_AXI_RREADY;
    hist_ok = 1'b1;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || expq.size() > 0) && n < budget) begin
      step();
      n++;
    end
    total++;
    if (q0.size() > 0 || q1.size() > 0 || expq.size() > 0) begin
      bad++; $display("FAIL timeout: %0d/%0d/%0d left after %0d cycles", q0.size(), q1.size(), expq.size(), n);
      q0.delete(); q1.delete(); expq.delete();
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); expq.delete();
    ptr_m = 1'b0; last_rdata_m = '0; hist_ok = 1'b0; fp = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_resp, busy, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
         M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR} !== '0) begin
      bad++;
      $display("FAIL %s: outputs not zero in reset: ready=%b rsp=%b rdata=%h resp=%b busy=%b aw=%b w=%b b=%b ar=%b r=%b",
               tag, req_ready, rsp_valid, rsp_rdata, rsp_resp, busy, M_AXI_AWVALID, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    req_valid = 2'b11; req_write = 2'b01; req_addr = '0; req_wdata = '0;
    model_reset();
    #3;
    check_all_zero("reset_state");
    repeat (2) @(negedge ACLK);
    #1;
    check_all_zero("reset_hold");
    req_valid = 2'b00;
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_basic();
    set_slave(0, 0, 0, 0, 0);
    active = 2'b01;
    q0.push_back('{wr: 1'b1, addr: 32'h0000_0000, data: 32'h0101_FFFF});
    q0.push_back('{wr: 1'b0, addr: 32'h0000_0000, data: 32'h0000_0000});
    run_until_done(100);
    total++;
    if (rsp_rdata !== 32'h0101_FFFF) begin
      bad++; $display("FAIL basic_readback: rdata=%h want 0101ffff", rsp_rdata);
    end
  endtask

  task automatic test_fairness();
    int n0 = 0;
    int n1 = 0;
    grant_log.delete();
    active = 2'b11;
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{wr: 1'b1, addr: 32'h100 + 32'(i * 4), data: $urandom()});
      q1.push_back('{wr: 1'b1, addr: 32'h200 + 32'(i * 4), data: $urandom()});
    end
    run_until_done(300);
    for (int k = 0; k < grant_log.size(); k++) begin
      if (grant_log[k] == 0) n0++; else n1++;
      if (k > 0) begin
        total++;
        if (grant_log[k] == grant_log[k-1]) begin
          bad++; $display("FAIL alternate: grant %0d to %0d twice in a row", k, grant_log[k]);
        end
      end
    end
    total++;
    if (n0 != 4 || n1 != 4) begin
      bad++; $display("FAIL fairness: grants req0=%0d req1=%0d want 4/4", n0, n1);
    end
  endtask

  task automatic test_aw_delay();
    set_slave(3, 0, 1, 0, 0);
    aw_only_cycles = 0;
    active = 2'b10;
    q1.push_back('{wr: 1'b1, addr: 32'h40, data: 32'hA5A5_0F0F});
    run_until_done(100);
    total++;
    if (aw_only_cycles < 3) begin
      bad++; $display("FAIL aw_delay: AW-only cycles=%0d want >=3", aw_only_cycles);
    end
    set_slave(0, 0, 0, 0, 0);
  endtask

  task automatic test_error_resp();
    bresp_cfg = 2'b10;
    rresp_cfg = 2'b11;
    active = 2'b11;
    q1.push_back('{wr: 1'b1, addr: 32'h80, data: 32'h1234_5678});
    q0.push_back('{wr: 1'b0, addr: 32'h40, data: 32'h0});
    run_until_done(100);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b00;
    q0.push_back('{wr: 1'b1, addr: 32'h80, data: 32'h8765_4321});
    q0.push_back('{wr: 1'b0, addr: 32'h80, data: 32'h0});
    run_until_done(100);
  endtask

  task automatic test_random();
    rand_dly = 1'b1;
    rand_withdraw = 1'b1;
    active = 2'b11;
    for (int i = 0; i < 30; i++) begin
      q0.push_back('{wr: 1'($urandom_range(0, 1)), addr: 32'($urandom_range(0, 7) * 4), data: $urandom()});
      q1.push_back('{wr: 1'($urandom_range(0, 1)), addr: 32'($urandom_range(0, 7) * 4), data: $urandom()});
    end
    run_until_done(3000);
    rand_dly = 1'b0;
    rand_withdraw = 1'b0;
    set_slave(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    set_slave(0, 0, 0, 0, 30);
    active = 2'b01;
    q0.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0});
    while (!M_AXI_RREADY && n < 50) begin
      step();
      n++;
    end
    total++;
    if (!M_AXI_RREADY) begin
      bad++; $display("FAIL reach_rresp: RREADY=%b after %0d cycles", M_AXI_RREADY, n);
    end
    #2;
    ARESETN = 1'b0;
    req_valid = 2'b11;
    #1;
    check_all_zero("reset_async");
    model_reset();
    repeat (3) begin
      @(negedge ACLK);
      #1;
      check_all_zero("reset_mid_hold");
    end
    req_valid = 2'b00;
    set_slave(0, 0, 0, 0, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    grant_log.delete();
    active = 2'b11;
    q0.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0});
    q1.push_back('{wr: 1'b1, addr: 32'h14, data: 32'hCAFE_F00D});
    run_until_done(100);
    total++;
    if (grant_log.size() == 0 || grant_log[0] != 0) begin
      bad++; $display("FAIL post_reset_grant: first grant=%0d want 0", grant_log.size() > 0 ? grant_log[0] : -1);
    end
  endtask

  initial begin
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rand_dly = 1'b0; rand_withdraw = 1'b0;
    active = 2'b00; aw_only_cycles = 0;
    set_slave(0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_fairness();
    test_aw_delay();
    test_error_resp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_bus_arbiter.md
CTRL_BUS_ARBITER -- requirements
Module: ctrl_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width; full-word accesses only.
REQ-003 ACLK  input  1  sole clock; all logic on rising edge.
REQ-004 ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  bit i: requester i has a pending command.
REQ-006 req_write  input  2  bit i: 1 = write, 0 = read, for requester i.
REQ-007 req_addr  input  2*ADDR_WIDTH  slice i: requester i byte address.
REQ-008 req_wdata  input  2*DATA_WIDTH  slice i: requester i write data.
REQ-009 req_ready  output  2  bit i: one-cycle grant pulse; command captured.
REQ-010 rsp_valid  output  2  bit i: one-cycle completion pulse to requester i.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data of the last completed read.
REQ-012 rsp_resp  output  2  BRESP/RRESP of the last completed transaction.
REQ-013 busy  output  1  high whenever FSM is not IDLE.
REQ-014 M_AXI_AWADDR/AWVALID out, M_AXI_AWREADY in  ADDR_WIDTH/1/1  write address channel.
REQ-015 M_AXI_WDATA/WVALID out, M_AXI_WREADY in  DATA_WIDTH/1/1  write data channel; downstream ties WSTRB all-ones and PROT to 0.
REQ-016 M_AXI_BRESP/BVALID in, M_AXI_BREADY out  2/1/1  write response channel.
REQ-017 M_AXI_ARADDR/ARVALID out, M_AXI_ARREADY in  ADDR_WIDTH/1/1  read address channel.
REQ-018 M_AXI_RDATA/RRESP/RVALID in, M_AXI_RREADY out  DATA_WIDTH/2/1/1  read data channel.

Function
REQ-019 FSM states SHALL be IDLE, WADDR (AW and/or W outstanding), WRESP, RADDR, RRESP; at most one AXI transaction outstanding.
REQ-020 In IDLE with any req_valid set, arbiter SHALL grant one requester in that cycle N: req_ready[i]=1, capture addr/wdata/write into registers, go to WADDR or RADDR.
REQ-021 Arbitration SHALL be round-robin: priority pointer starts at requester 0; after granting i, requester 1-i has priority; single requester is granted regardless of pointer.
REQ-022 WADDR: AWVALID and WVALID SHALL both rise at N+1; each SHALL drop in the cycle after its own handshake; transition to WRESP after both handshakes, including same-cycle handshakes.
REQ-023 RADDR: ARVALID SHALL rise at N+1 and hold until ARREADY; then RRESP.
REQ-024 BREADY SHALL be high only in WRESP; RREADY only in RRESP.
REQ-025 On B (or R) handshake in cycle M: rsp_valid[i]=1 at M+1 for exactly one cycle, rsp_resp=BRESP/RRESP, rsp_rdata=RDATA for reads (unchanged for writes); FSM IDLE at M+1 and may grant at M+1.
REQ-026 AXI address/data outputs SHALL remain stable while their VALID is high.
REQ-027 Requests arriving while busy SHALL wait; req_valid withdrawn before grant SHALL be ignored without side effects.
REQ-028 Non-OKAY responses SHALL be passed through unchanged; no retry.

Reset
REQ-029 ARESETN low SHALL immediately force: FSM IDLE, pointer to 0, req_ready, rsp_valid, busy, all AXI VALID/READY outputs 0, rsp_rdata, rsp_resp, addr/data outputs 0; mid-transaction reset abandons the transaction with no rsp_valid.
REQ-030 Operation SHALL resume on the first rising ACLK after ARESETN deasserts.

Verification
REQ-031 Req0 write 0x0101FFFF to 0x0, slave ready immediately -> req_ready[0] at N, AW/W at N+1, rsp_valid[0] with rsp_resp=00; read of 0x0 returns rsp_rdata=0x0101FFFF.
REQ-032 Both requesters assert continuously for 4 commands each -> grants alternate 0,1,0,1...; no requester starved.
REQ-033 AWREADY delayed 3 cycles after WREADY -> WVALID drops after W handshake, AWVALID held stable; single rsp_valid.
REQ-034 Slave returns BRESP=10 -> rsp_resp=10 delivered to correct requester; next grant proceeds.
REQ-035 ARESETN pulsed low while in RRESP -> all outputs 0 asynchronously, no rsp_valid; next request after reset granted to requester 0.
